// File: rtl/row_cnt_fetch_ctrl.sv
// Per-column read sequencer that streams row counts from the ROW count banks into the PE columns.
// Each channel hides the bank's 1-cycle read latency behind a 3-entry skid FIFO and yields the bank to SPI writes.
module row_cnt_fetch_ctrl #(
    parameter  int N_PE_COL       = 5,
    parameter  int DEPTH_ROW_BANK = 2048,
    localparam int AW             = $clog2(DEPTH_ROW_BANK)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PE_COL-1:0]         start,
    input  logic [N_PE_COL-1:0][AW-1:0] base_addr,
    input  logic [N_PE_COL-1:0][AW:0]   num_rows,
    input  logic [N_PE_COL-1:0]         spi_wen_row_bank_sync,
    output logic [N_PE_COL-1:0][AW-1:0] raddr_row_cnt_bank,
    output logic [N_PE_COL-1:0]         ren_row_cnt_bank,
    input  logic [N_PE_COL-1:0][5:0]    row_cnt_data,
    output logic [N_PE_COL-1:0]         cnt_valid,
    output logic [N_PE_COL-1:0][5:0]    cnt_data,
    output logic [N_PE_COL-1:0]         cnt_last,
    input  logic [N_PE_COL-1:0]         cnt_ready,
    output logic [N_PE_COL-1:0]         busy,
    output logic [N_PE_COL-1:0]         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH_ROW_BANK - 1);
    localparam logic [AW:0]   REM_ONE  = (AW+1)'(1);

    for (genvar c = 0; c < N_PE_COL; c++) begin : g_ch
        state_t        state_q, state_d;
        logic [AW-1:0] addr_q;
        logic [AW-1:0] raddr_q;
        logic [AW:0]   remaining_q;
        logic          inflight_q;
        logic          inflight_last_q;
        logic [1:0]    wr_ptr_q, rd_ptr_q;
        logic [1:0]    occ_q;
        logic          done_q;
        logic [6:0]    fifo_mem [3];
        logic [6:0]    head;
        logic          ren, push, pop, valid, start_ok;

        assign valid    = (occ_q != 2'd0);
        assign pop      = valid & cnt_ready[c];
        assign push     = inflight_q;
        assign head     = fifo_mem[rd_ptr_q];
        assign start_ok = (state_q == IDLE) & start[c];

        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            ren     = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start[c] && num_rows[c] != '0)
                        state_d = FETCH;
                end
                FETCH: begin
                    // Reserve a FIFO slot for the read already in flight so a stalled consumer never overflows it.
                    ren = (remaining_q != '0) && !spi_wen_row_bank_sync[c] &&
                          (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
                    if (ren && remaining_q == REM_ONE)
                        state_d = DRAIN;
                end
                DRAIN: begin
                    if (pop && head[0])
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q         <= IDLE;
                addr_q          <= '0;
                raddr_q         <= '0;
                remaining_q     <= '0;
                inflight_q      <= 1'b0;
                inflight_last_q <= 1'b0;
                wr_ptr_q        <= 2'd0;
                rd_ptr_q        <= 2'd0;
                occ_q           <= 2'd0;
                done_q          <= 1'b0;
            end else begin
                state_q         <= state_d;
                inflight_q      <= ren;
                inflight_last_q <= ren && (remaining_q == REM_ONE);
                done_q          <= (start_ok && num_rows[c] == '0) ||
                                   (state_q == DRAIN && pop && head[0]);

                if (start_ok) begin
                    addr_q      <= base_addr[c];
                    remaining_q <= num_rows[c];
                end else if (ren) begin
                    addr_q      <= (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
                    raddr_q     <= addr_q;
                end

                if (push)
                    wr_ptr_q <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
                if (pop)
                    rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;

                case ({push, pop})
                    2'b10:   occ_q <= occ_q + 2'd1;
                    2'b01:   occ_q <= occ_q - 2'd1;
                    default: occ_q <= occ_q;
                endcase
            end
        end

        // NOTE: FIFO storage is not reset; occupancy gates every read of it, so stale contents are never visible.
        always_ff @(posedge clk) begin
            if (push)
                fifo_mem[wr_ptr_q] <= {row_cnt_data[c], inflight_last_q};
        end

        assign ren_row_cnt_bank[c]   = ren;
        assign raddr_row_cnt_bank[c] = ren ? addr_q : raddr_q;
        assign cnt_valid[c]          = valid;
        assign cnt_data[c]           = valid ? head[6:1] : 6'd0;
        assign cnt_last[c]           = valid & head[0];
        assign busy[c]               = (state_q != IDLE);
        assign done[c]               = done_q;
    end

endmodule

// File: tb/tb_row_cnt_fetch_ctrl.sv
// Self-checking bench for row_cnt_fetch_ctrl: a bank model feeds read data, a scoreboard
// queue per channel holds the expected words/addresses and a negedge monitor compares them.
module tb_row_cnt_fetch_ctrl;

    localparam int N     = 5;
    localparam int DEPTH = 2048;
    localparam int AW    = $clog2(DEPTH);

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         start;
    logic [N-1:0][AW-1:0] base_addr;
    logic [N-1:0][AW:0]   num_rows;
    logic [N-1:0]         spi_wen;
    logic [N-1:0][AW-1:0] raddr;
    logic [N-1:0]         ren;
    logic [N-1:0][5:0]    row_cnt_data;
    logic [N-1:0]         cnt_valid;
    logic [N-1:0][5:0]    cnt_data;
    logic [N-1:0]         cnt_last;
    logic [N-1:0]         cnt_ready;
    logic [N-1:0]         busy;
    logic [N-1:0]         done;

    logic [5:0] bank [N][DEPTH];
    logic [6:0] exp_word [N][$];
    int         exp_addr [N][$];
    int         exp_done [N];
    int         obs_done [N];
    int         ren_cnt  [N];
    int         cmd_base [N];
    int         cmd_n    [N];
    int         checks   = 0;
    int         failures = 0;

    bit           rand_ready = 0;
    bit           rand_spi   = 0;
    logic [N-1:0] ready_force;
    logic [N-1:0] spi_force;

    logic [6:0] mon_w;
    int         mon_a;

    row_cnt_fetch_ctrl #(
        .N_PE_COL       (N),
        .DEPTH_ROW_BANK (DEPTH)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .base_addr             (base_addr),
        .num_rows              (num_rows),
        .spi_wen_row_bank_sync (spi_wen),
        .raddr_row_cnt_bank    (raddr),
        .ren_row_cnt_bank      (ren),
        .row_cnt_data          (row_cnt_data),
        .cnt_valid             (cnt_valid),
        .cnt_data              (cnt_data),
        .cnt_last              (cnt_last),
        .cnt_ready             (cnt_ready),
        .busy                  (busy),
        .done                  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read bank: data appears the cycle after ren.
    always @(posedge clk) begin
        for (int c = 0; c < N; c++)
            if (ren[c]) row_cnt_data[c] <= bank[c][raddr[c]];
    end

    // Sole driver of cnt_ready and spi_wen, either random or the forced value from the main sequence.
    initial begin
        cnt_ready = '1;
        spi_wen   = '0;
        forever begin
            @(posedge clk);
            #2;
            cnt_ready = rand_ready ? N'($urandom) : ready_force;
            for (int c = 0; c < N; c++)
                spi_wen[c] = rand_spi ? ($urandom_range(0, 3) == 0) : spi_force[c];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N; c++) begin
                if (ren[c]) begin
                    ren_cnt[c]++;
                    check($sformatf("ren_while_spi_ch%0d", c), spi_wen[c], 1'b0);
                    check($sformatf("addr_expected_ch%0d", c), exp_addr[c].size() != 0, 1'b1);
                    if (exp_addr[c].size() != 0) begin
                        mon_a = exp_addr[c].pop_front();
                        check($sformatf("raddr_ch%0d", c), raddr[c], mon_a);
                    end
                end
                if (cnt_valid[c] && cnt_ready[c]) begin
                    check($sformatf("word_expected_ch%0d", c), exp_word[c].size() != 0, 1'b1);
                    if (exp_word[c].size() != 0) begin
                        mon_w = exp_word[c].pop_front();
                        check($sformatf("cnt_data_ch%0d", c), cnt_data[c], mon_w[6:1]);
                        check($sformatf("cnt_last_ch%0d", c), cnt_last[c], mon_w[0]);
                    end
                end
                if (done[c]) obs_done[c]++;
            end
        end
    end

    // Reference model: a stream is simply the words base..base+n-1 modulo the bank depth, last on the final one.
    task automatic model_start(input int c, input int base, input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            a = (base + i) % DEPTH;
            exp_addr[c].push_back(a);
            exp_word[c].push_back({bank[c][a], (i == n - 1) ? 1'b1 : 1'b0});
        end
        exp_done[c]++;
    endtask

    task automatic issue(input logic [N-1:0] mask);
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (mask[c]) begin
                start[c]     = 1'b1;
                base_addr[c] = AW'(cmd_base[c]);
                num_rows[c]  = (AW+1)'(cmd_n[c]);
                model_start(c, cmd_base[c], cmd_n[c]);
            end
        end
        @(posedge clk);
        #1;
        start = '0;
    endtask

    task automatic wait_idle(input string tag);
        int  left;
        bit  idle;
        left = 20000;
        idle = 1'b0;
        while (!idle && left > 0) begin
            @(negedge clk);
            left--;
            idle = (busy == '0);
            for (int c = 0; c < N; c++)
                if (exp_word[c].size() != 0) idle = 1'b0;
        end
        check({tag, "_idle_in_time"}, idle, 1'b1);
        repeat (2) @(negedge clk);
        for (int c = 0; c < N; c++)
            check($sformatf("%s_done_count_ch%0d", tag, c), obs_done[c], exp_done[c]);
    endtask

    initial begin
        int r0;
        int n_ren;
        int done_at;

        rst         = 1'b1;
        start       = '0;
        base_addr   = '0;
        num_rows    = '0;
        ready_force = '1;
        spi_force   = '0;
        for (int c = 0; c < N; c++) begin
            exp_done[c] = 0;
            obs_done[c] = 0;
            ren_cnt[c]  = 0;
            cmd_base[c] = 0;
            cmd_n[c]    = 0;
            for (int a = 0; a < DEPTH; a++) bank[c][a] = 6'($urandom);
        end
        for (int i = 0; i < 4; i++) bank[0][10 + i] = 6'(i + 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ren", ren, '0);
        check("rst_raddr", raddr, '0);
        check("rst_cnt_valid", cnt_valid, '0);
        check("rst_cnt_data", cnt_data, '0);
        check("rst_cnt_last", cnt_last, '0);
        check("rst_busy", busy, '0);
        check("rst_done", done, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic stream with cycle-exact latency relative to the start cycle T.
        cmd_base[0] = 10;
        cmd_n[0]    = 4;
        issue(5'b00001);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("t1_busy_T%0d", k), busy[0], k <= 6);
            check($sformatf("t1_ren_T%0d", k), ren[0], k <= 4);
            check($sformatf("t1_valid_T%0d", k), cnt_valid[0], (k >= 3) && (k <= 6));
            if (k >= 3 && k <= 6)
                check($sformatf("t1_data_T%0d", k), cnt_data[0], k - 2);
            check($sformatf("t1_last_T%0d", k), cnt_last[0], k == 6);
            check($sformatf("t1_done_T%0d", k), done[0], k == 7);
        end
        wait_idle("t1");

        // Consumer stalled until T+10: only three reads may be outstanding.
        @(posedge clk);
        #1;
        ready_force[0] = 1'b0;
        r0 = ren_cnt[0];
        issue(5'b00001);
        n_ren = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ren[0]) n_ren++;
        end
        check("t2_ren_while_stalled", n_ren, 3);
        check("t2_buffered_valid", cnt_valid[0], 1'b1);
        @(posedge clk);
        #1;
        ready_force[0] = 1'b1;
        wait_idle("t2");
        check("t2_total_ren", ren_cnt[0] - r0, 4);

        // SPI owns the bank during T+2..T+3: completion slips by two cycles.
        r0 = ren_cnt[0];
        issue(5'b00001);
        @(posedge clk);
        #1;
        spi_force[0] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        spi_force[0] = 1'b0;
        done_at = -1;
        for (int k = 4; k <= 30; k++) begin
            @(negedge clk);
            if (done[0] && done_at < 0) done_at = k;
        end
        check("t3_done_cycle", done_at, 9);
        wait_idle("t3");
        check("t3_total_ren", ren_cnt[0] - r0, 4);

        // Address wrap at the top of the bank.
        cmd_base[3] = 2046;
        cmd_n[3]    = 4;
        issue(5'b01000);
        wait_idle("t4");

        // Zero-length command: done next cycle, nothing else.
        cmd_base[2] = 33;
        cmd_n[2]    = 0;
        r0 = ren_cnt[2];
        issue(5'b00100);
        @(negedge clk);
        check("t5_zero_done", done[2], 1'b1);
        check("t5_zero_busy", busy[2], 1'b0);
        check("t5_zero_ren", ren[2], 1'b0);
        @(negedge clk);
        check("t5_zero_done_pulse", done[2], 1'b0);
        wait_idle("t5a");
        check("t5_zero_total_ren", ren_cnt[2] - r0, 0);

        // A start while busy must not be taken.
        cmd_base[1] = 100;
        cmd_n[1]    = 6;
        r0 = ren_cnt[1];
        issue(5'b00010);
        @(posedge clk);
        #1;
        start[1]     = 1'b1;
        base_addr[1] = AW'(500);
        num_rows[1]  = (AW+1)'(3);
        @(posedge clk);
        #1;
        start = '0;
        wait_idle("t5b");
        check("t5_busy_start_total_ren", ren_cnt[1] - r0, 6);

        // All channels with lengths 1,2,3,5,8 and a random consumer.
        rand_ready = 1'b1;
        cmd_n[0] = 1;
        cmd_n[1] = 2;
        cmd_n[2] = 3;
        cmd_n[3] = 5;
        cmd_n[4] = 8;
        for (int c = 0; c < N; c++) cmd_base[c] = $urandom_range(0, DEPTH - 1);
        issue('1);
        wait_idle("t6");

        // Random rounds with SPI interference.
        rand_spi = 1'b1;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < N; c++) begin
                cmd_base[c] = $urandom_range(0, DEPTH - 1);
                cmd_n[c]    = $urandom_range(0, 24);
            end
            issue('1);
            wait_idle($sformatf("rnd%0d", r));
        end
        rand_spi = 1'b0;

        // Full-bank stream starting mid-bank.
        cmd_base[4] = 700;
        cmd_n[4]    = DEPTH;
        r0 = ren_cnt[4];
        issue(5'b10000);
        wait_idle("full");
        check("full_total_ren", ren_cnt[4] - r0, DEPTH);

        // Reset mid-stream.
        for (int c = 0; c < N; c++) begin
            cmd_base[c] = $urandom_range(0, DEPTH - 1);
            cmd_n[c]    = 20;
        end
        issue('1);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ren", ren, '0);
        check("mid_rst_cnt_valid", cnt_valid, '0);
        check("mid_rst_cnt_data", cnt_data, '0);
        check("mid_rst_cnt_last", cnt_last, '0);
        check("mid_rst_busy", busy, '0);
        check("mid_rst_done", done, '0);
        for (int c = 0; c < N; c++) begin
            exp_word[c].delete();
            exp_addr[c].delete();
            exp_done[c] = 0;
            obs_done[c] = 0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        for (int c = 0; c < N; c++)
            check($sformatf("no_done_after_rst_ch%0d", c), obs_done[c], 0);

        // Recovery after reset.
        cmd_base[0] = 2047;
        cmd_n[0]    = 3;
        issue(5'b00001);
        wait_idle("post_rst");
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
